// File: rtl/tone_arbiter.sv
// rtl/tone_arbiter.sv - fixed-priority tone source arbiter with minimum hold and silence gap
module tone_arbiter #(
  parameter int MIN_HOLD = 400000,
  parameter int GAP      = 40000,
  parameter int CNT_W    = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] mode0,
  input  logic [2:0] mode1,
  input  logic [2:0] mode2,
  input  logic [1:0] hl0,
  input  logic [1:0] hl1,
  input  logic [1:0] hl2,
  input  logic       mute,
  output logic [2:0] mode,
  output logic [1:0] HL,
  output logic [2:0] gnt,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  // Silent output is note 0 at normal octave.
  localparam logic [2:0] MODE_SILENT = 3'd0;
  localparam logic [1:0] HL_SILENT   = 2'd1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic [CNT_W-1:0] gap_cnt, gap_nx;
  logic [2:0]       gnt_nx;
  logic [2:0]       mode_nx;
  logic [1:0]       hl_nx;
  logic             busy_nx;

  logic [2:0]       win;
  logic [2:0]       win_mode, own_mode;
  logic [1:0]       win_hl, own_hl;
  logic             own_req, hi_req;

  // Lowest asserted index wins a fresh arbitration.
  always_comb begin
    win = 3'b000;
    if (req[0])      win = 3'b001;
    else if (req[1]) win = 3'b010;
    else if (req[2]) win = 3'b100;
  end

  // Steer the selected requester's note/octave for both a new winner and the current owner.
  always_comb begin
    win_mode = MODE_SILENT;
    win_hl   = HL_SILENT;
    own_mode = MODE_SILENT;
    own_hl   = HL_SILENT;
    case (win)
      3'b001:  begin win_mode = mode0; win_hl = hl0; end
      3'b010:  begin win_mode = mode1; win_hl = hl1; end
      3'b100:  begin win_mode = mode2; win_hl = hl2; end
      default: ;
    endcase
    case (gnt)
      3'b001:  begin own_mode = mode0; own_hl = hl0; end
      3'b010:  begin own_mode = mode1; own_hl = hl1; end
      3'b100:  begin own_mode = mode2; own_hl = hl2; end
      default: ;
    endcase
  end

  // Owner still requesting, and any strictly higher-priority requester (indices below the owner bit).
  assign own_req = |(req & gnt);
  assign hi_req  = |(req & (gnt - 3'd1));

  // Next-state, counter and output computation; mute only touches mode/HL.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    gap_nx   = gap_cnt;
    gnt_nx   = gnt;
    mode_nx  = MODE_SILENT;
    hl_nx    = HL_SILENT;
    case (state)
      S_IDLE: begin
        gnt_nx = 3'b000;
        if (|req) begin
          state_nx = S_OWN;
          gnt_nx   = win;
          hold_nx  = HOLD_INIT;
          if (!mute) begin
            mode_nx = win_mode;
            hl_nx   = win_hl;
          end
        end
      end
      S_OWN: begin
        if (!own_req || (hi_req && hold_cnt == CNT_ZERO)) begin
          state_nx = S_GAP;
          gnt_nx   = 3'b000;
          gap_nx   = GAP_INIT;
        end else begin
          if (hold_cnt != CNT_ZERO) hold_nx = hold_cnt - CNT_ONE;
          if (!mute) begin
            mode_nx = own_mode;
            hl_nx   = own_hl;
          end
        end
      end
      S_GAP: begin
        gnt_nx = 3'b000;
        if (gap_cnt == CNT_ZERO) begin
          if (|req) begin
            state_nx = S_OWN;
            gnt_nx   = win;
            hold_nx  = HOLD_INIT;
            if (!mute) begin
              mode_nx = win_mode;
              hl_nx   = win_hl;
            end
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          gap_nx = gap_cnt - CNT_ONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        gnt_nx   = 3'b000;
      end
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  // State, counters and registered tone outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hold_cnt <= CNT_ZERO;
      gap_cnt  <= CNT_ZERO;
      gnt      <= 3'b000;
      mode     <= MODE_SILENT;
      HL       <= HL_SILENT;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      gap_cnt  <= gap_nx;
      gnt      <= gnt_nx;
      mode     <= mode_nx;
      HL       <= hl_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_tone_arbiter.sv
// tb/tb_tone_arbiter.sv - directed bench for tone_arbiter with MIN_HOLD=8, GAP=3
module tb_tone_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [2:0] mode0, mode1, mode2;
  logic [1:0] hl0, hl1, hl2;
  logic       mute;
  logic [2:0] mode;
  logic [1:0] HL;
  logic [2:0] gnt;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  tone_arbiter #(.MIN_HOLD(8), .GAP(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .mode0(mode0), .mode1(mode1), .mode2(mode2),
    .hl0(hl0), .hl1(hl1), .hl2(hl2),
    .mute(mute), .mode(mode), .HL(HL), .gnt(gnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // One active edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drop all requests and let any gap run out.
  task automatic go_idle();
    req = 3'b000;
    repeat (5) step();
    vectors++; if (busy !== 1'b0) begin $display("FAIL go_idle_busy got %b want 0", busy); miscompares++; end
    vectors++; if (gnt !== 3'b000) begin $display("FAIL go_idle_gnt got %b want 000", gnt); miscompares++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b111; mute = 1'b0;
    mode0 = 3'd2; mode1 = 3'd4; mode2 = 3'd6; hl0 = 2'd2; hl1 = 2'd0; hl2 = 2'd1;
    step(); step();
    vectors++; if (mode !== 3'd0)   begin $display("FAIL reset_mode got %0d want 0", mode); miscompares++; end
    vectors++; if (HL !== 2'd1)     begin $display("FAIL reset_hl got %0d want 1", HL); miscompares++; end
    vectors++; if (gnt !== 3'b000)  begin $display("FAIL reset_gnt got %b want 000", gnt); miscompares++; end
    vectors++; if (busy !== 1'b0)   begin $display("FAIL reset_busy got %b want 0", busy); miscompares++; end
    rst = 1'b0;
    step();
    vectors++; if (gnt !== 3'b001)  begin $display("FAIL reset_first_gnt got %b want 001", gnt); miscompares++; end
    vectors++; if (mode !== 3'd2)   begin $display("FAIL reset_first_mode got %0d want 2", mode); miscompares++; end
    vectors++; if (HL !== 2'd2)     begin $display("FAIL reset_first_hl got %0d want 2", HL); miscompares++; end
    vectors++; if (busy !== 1'b1)   begin $display("FAIL reset_first_busy got %b want 1", busy); miscompares++; end
    go_idle();
  endtask

  task automatic test_melody();
    req = 3'b100; mode2 = 3'd5; hl2 = 2'd1;
    step();
    vectors++; if (gnt !== 3'b100) begin $display("FAIL melody_gnt got %b want 100", gnt); miscompares++; end
    vectors++; if (mode !== 3'd5)  begin $display("FAIL melody_mode got %0d want 5", mode); miscompares++; end
    vectors++; if (HL !== 2'd1)    begin $display("FAIL melody_hl got %0d want 1", HL); miscompares++; end
    mode2 = 3'd3;
    step();
    vectors++; if (mode !== 3'd3)  begin $display("FAIL melody_mode_change got %0d want 3", mode); miscompares++; end
    hl2 = 2'd2;
    step();
    vectors++; if (HL !== 2'd2)    begin $display("FAIL melody_hl_change got %0d want 2", HL); miscompares++; end
    go_idle();
  endtask

  task automatic test_preempt();
    req = 3'b100; mode2 = 3'd5; hl2 = 2'd1; mode0 = 3'd7; hl0 = 2'd0;
    step();                       // edge k
    vectors++; if (gnt !== 3'b100) begin $display("FAIL preempt_start_gnt got %b want 100", gnt); miscompares++; end
    step();                       // edge k+1
    req = 3'b101;                 // alarm seen from edge k+2
    for (int e = 2; e <= 7; e++) begin
      step();
      vectors++; if (gnt !== 3'b100) begin $display("FAIL preempt_hold_e%0d got %b want 100", e, gnt); miscompares++; end
    end
    step();                       // edge k+8
    vectors++; if (gnt !== 3'b000) begin $display("FAIL preempt_gap_gnt got %b want 000", gnt); miscompares++; end
    vectors++; if (mode !== 3'd0)  begin $display("FAIL preempt_gap_mode got %0d want 0", mode); miscompares++; end
    vectors++; if (busy !== 1'b1)  begin $display("FAIL preempt_gap_busy got %b want 1", busy); miscompares++; end
    for (int e = 9; e <= 10; e++) begin
      step();
      vectors++; if (gnt !== 3'b000) begin $display("FAIL preempt_gap_e%0d got %b want 000", e, gnt); miscompares++; end
    end
    step();                       // edge k+11
    vectors++; if (gnt !== 3'b001) begin $display("FAIL preempt_new_gnt got %b want 001", gnt); miscompares++; end
    vectors++; if (mode !== 3'd7)  begin $display("FAIL preempt_new_mode got %0d want 7", mode); miscompares++; end
    vectors++; if (HL !== 2'd0)    begin $display("FAIL preempt_new_hl got %0d want 0", HL); miscompares++; end
    go_idle();
  endtask

  task automatic test_owner_drop();
    mode1 = 3'd4; hl1 = 2'd2; mode2 = 3'd1; hl2 = 2'd0;
    req = 3'b010;
    step();
    vectors++; if (gnt !== 3'b010) begin $display("FAIL drop_beep_gnt got %b want 010", gnt); miscompares++; end
    req = 3'b110;                 // lower priority melody must not preempt
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++; if (gnt !== 3'b010) begin $display("FAIL drop_lowpri_c%0d got %b want 010", i, gnt); miscompares++; end
    end
    req = 3'b100;                 // edge j: beep drops
    step();
    vectors++; if (mode !== 3'd0)  begin $display("FAIL drop_mode got %0d want 0", mode); miscompares++; end
    vectors++; if (gnt !== 3'b000) begin $display("FAIL drop_gnt got %b want 000", gnt); miscompares++; end
    step(); step();
    vectors++; if (gnt !== 3'b000) begin $display("FAIL drop_gap_end got %b want 000", gnt); miscompares++; end
    step();                       // edge j+3
    vectors++; if (gnt !== 3'b100) begin $display("FAIL drop_new_gnt got %b want 100", gnt); miscompares++; end
    vectors++; if (mode !== 3'd1)  begin $display("FAIL drop_new_mode got %0d want 1", mode); miscompares++; end
    go_idle();
    req = 3'b010;
    step();
    req = 3'b000;                 // edge j: drop with nobody waiting
    step();
    vectors++; if (busy !== 1'b1)  begin $display("FAIL drop_idle_busy_gap got %b want 1", busy); miscompares++; end
    step(); step();
    vectors++; if (busy !== 1'b1)  begin $display("FAIL drop_idle_busy_gap2 got %b want 1", busy); miscompares++; end
    step();                       // edge j+3
    vectors++; if (busy !== 1'b0)  begin $display("FAIL drop_idle_busy got %b want 0", busy); miscompares++; end
    vectors++; if (gnt !== 3'b000) begin $display("FAIL drop_idle_gnt got %b want 000", gnt); miscompares++; end
  endtask

  task automatic test_mute();
    req = 3'b100; mode2 = 3'd6; hl2 = 2'd2;
    step();
    vectors++; if (mode !== 3'd6) begin $display("FAIL mute_pre_mode got %0d want 6", mode); miscompares++; end
    mute = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (mode !== 3'd0)  begin $display("FAIL mute_mode_c%0d got %0d want 0", i, mode); miscompares++; end
      vectors++; if (HL !== 2'd1)    begin $display("FAIL mute_hl_c%0d got %0d want 1", i, HL); miscompares++; end
      vectors++; if (gnt !== 3'b100) begin $display("FAIL mute_gnt_c%0d got %b want 100", i, gnt); miscompares++; end
    end
    mute = 1'b0;
    step();
    vectors++; if (mode !== 3'd6) begin $display("FAIL mute_release_mode got %0d want 6", mode); miscompares++; end
    vectors++; if (HL !== 2'd2)   begin $display("FAIL mute_release_hl got %0d want 2", HL); miscompares++; end
    go_idle();
  endtask

  task automatic test_reset_in_gap();
    req = 3'b100; mode2 = 3'd3; hl2 = 2'd0;
    step();
    req = 3'b000;
    step();                       // gap cycle 1
    step();                       // gap cycle 2
    rst = 1'b1; req = 3'b100;
    step();
    vectors++; if (gnt !== 3'b000) begin $display("FAIL rstgap_gnt got %b want 000", gnt); miscompares++; end
    vectors++; if (mode !== 3'd0)  begin $display("FAIL rstgap_mode got %0d want 0", mode); miscompares++; end
    vectors++; if (HL !== 2'd1)    begin $display("FAIL rstgap_hl got %0d want 1", HL); miscompares++; end
    vectors++; if (busy !== 1'b0)  begin $display("FAIL rstgap_busy got %b want 0", busy); miscompares++; end
    rst = 1'b0;
    step();
    vectors++; if (gnt !== 3'b100) begin $display("FAIL rstgap_regrant got %b want 100", gnt); miscompares++; end
    vectors++; if (mode !== 3'd3)  begin $display("FAIL rstgap_mode_after got %0d want 3", mode); miscompares++; end
    go_idle();
  endtask

  task automatic test_back_to_back();
    req = 3'b110; mode1 = 3'd2; hl1 = 2'd1;
    step();
    vectors++; if (gnt !== 3'b010) begin $display("FAIL b2b_priority got %b want 010", gnt); miscompares++; end
    req = 3'b000;
    step();
    req = 3'b010;                 // same owner still highest at gap exit
    step(); step();
    vectors++; if (gnt !== 3'b000) begin $display("FAIL b2b_gap got %b want 000", gnt); miscompares++; end
    step();
    vectors++; if (gnt !== 3'b010) begin $display("FAIL b2b_rewin got %b want 010", gnt); miscompares++; end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_melody();
    test_preempt();
    test_owner_drop();
    test_mute();
    test_reset_in_gap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tone_arbiter.md
# tone_arbiter

- Shares the single mode/HL tone-generator input between three requesters: alarm, key beep and melody player.
- Uses fixed priority, a minimum-hold time before preemption, and a forced silence gap on every ownership change so the buzzer does not click.
- Sits between the melody player/beep sources and the tone generator, in the 4 MHz clock domain.

## Interface
Parameters:
- MIN_HOLD, 400000 — cycles an owner keeps the grant before a higher-priority requester may preempt it (0.1 s at 4 MHz); must be ≥1.
- GAP, 40000 — silence cycles between owners (10 ms); must be ≥1.
- CNT_W, 22 — width of the hold and gap counters; must hold MIN_HOLD-1 and GAP-1.

Ports:
- clk  in  1  system clock, 4 MHz.
- rst  in  1  synchronous, active-high reset.
- req  in  3  level requests; bit0 = alarm (highest priority), bit1 = key beep, bit2 = melody (lowest).
- mode0, mode1, mode2  in  3 each  note code per requester (0 = silent, 1..7 = do..si).
- hl0, hl1, hl2  in  2 each  octave per requester (0 = low, 1 = normal, 2 = high).
- mute  in  1  forces silent output; arbitration is unaffected.
- mode  out  3  registered note code to the tone generator.
- HL  out  2  registered octave to the tone generator.
- gnt  out  3  one-hot grant, all zero when nobody owns.
- busy  out  1  high in OWN or GAP.

## Operation
- Three states: IDLE, OWN, GAP.
- Reset: state IDLE, gnt=0, mode=0, HL=1, busy=0, both counters 0.
- IDLE
  - Outputs mode=0, HL=1, gnt=0.
  - If any req bit is high, go to OWN; winner = lowest asserted index.
  - Hold counter loads MIN_HOLD-1.
  - No gap is inserted when leaving IDLE.
- OWN
  - Each cycle, mode/HL register the owner's modeN/hlN, unless mute is high (then mode=0, HL=1).
  - Hold counter decrements to 0 and saturates.
  - Go to GAP when:
    - the owner's req is low, at any counter value; or
    - a higher-priority req is high and the hold counter is 0.
  - Lower-priority requests never preempt.
  - Owner drop and higher-priority request in the same cycle: go to GAP (single gap).
- GAP
  - Outputs mode=0, HL=1, gnt=0.
  - Gap counter loads GAP-1 on entry and decrements.
  - When the gap counter is 0: go to OWN with a fresh arbitration among current req (hold counter reloads), or to IDLE if req=0.
  - Requests arriving or dropping during GAP affect only the arbitration at gap exit.
- The previous owner may win again after a gap if it is still the highest asserted requester.
- mute does not change state, counters or gnt; it only overrides mode/HL. This is how the melody is paused while keeping its place.
- Reset mid-OWN or mid-GAP: immediately IDLE with reset values; no gap is emitted.

## Timing
- req sampled high in IDLE at edge k: gnt and mode/HL (the owner's inputs sampled at edge k) are valid after edge k.
- In OWN, mode/HL follow the owner's inputs with exactly 1-cycle latency.
- Preemption: the earliest exit to GAP is at edge k+MIN_HOLD, so the owner holds at least MIN_HOLD cycles.
- Own-drop exit: owner req low at edge j gives gnt=0 and mode=0 after edge j.
- GAP entered at edge j: gnt is 0 for exactly GAP cycles; the new owner is valid after edge j+GAP.
- busy is high one cycle after the first req and falls after the GAP-exit edge that finds req=0.

## Test plan
(All scenarios use MIN_HOLD=8, GAP=3.)
1. Reset with req=3'b111:
   - While rst is high: mode=0, HL=1, gnt=0, busy=0.
   - First edge after rst falls: gnt=3'b001, mode=mode0.
2. Melody alone: req=3'b100, mode2=5, hl2=1.
   - After 1 edge: gnt=100, mode=5, HL=1.
   - Change mode2 to 3: mode=3 one edge later.
3. Preemption blocked by hold: melody granted at edge k, alarm req at edge k+2.
   - gnt stays 100 through edge k+7.
   - GAP from edge k+8; gnt=000 for 3 cycles.
   - gnt=001 after edge k+11.
4. Owner drop: beep owns, req1 falls at edge j while melody requests.
   - mode=0 after edge j.
   - gnt=100 after edge j+3.
   - req=0 during the gap instead: IDLE, busy=0 after edge j+3.
5. Mute: melody owns with mode2=6, mute high for 5 cycles.
   - mode=0, HL=1 during mute; gnt stays 100.
   - mode=6 one edge after mute falls.
6. Reset in GAP: rst at gap cycle 2.
   - Next edge: IDLE outputs.
   - With req=100 held: gnt=100 on the first edge after rst falls, no gap.
